xdma_h2c_dsc_scheduler: RTL

XDMA_H2C_DSC_SCHEDULER -- requirements
Module: xdma_h2c_dsc_scheduler

---
 rtl/xdma_h2c_dsc_scheduler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/xdma_h2c_dsc_scheduler.sv
// Round-robin H2C descriptor-bypass scheduler: arbitrates requesters onto one XDMA
// bypass channel and routes in-order completions back to the issuing requester.
module xdma_h2c_dsc_scheduler #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned MAX_OUT = 4,
    parameter logic [15:0] DSC_CTL = 16'h0013
) (
    input  logic                     axi_aclk,
    input  logic                     axi_areset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [64*N_REQ-1:0]      req_src_addr,
    input  logic [64*N_REQ-1:0]      req_dst_addr,
    input  logic [28*N_REQ-1:0]      req_len,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     h2c_dsc_byp_ready_0,
    output logic                     h2c_dsc_byp_load_0,
    output logic [63:0]              h2c_dsc_byp_src_addr_0,
    output logic [63:0]              h2c_dsc_byp_dst_addr_0,
    output logic [27:0]              h2c_dsc_byp_len_0,
    output logic [15:0]              h2c_dsc_byp_ctl_0,
    input  logic                     dsc_done,
    output logic [N_REQ-1:0]         done_vec,
    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic                     err_zero_len,
    output logic                     err_spurious
);

    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT) + 1;

    typedef enum logic {ARB, ISSUE} state_e;

    state_e            state_q, state_d;
    logic [63:0]       src_arr [N_REQ];
    logic [63:0]       dst_arr [N_REQ];
    logic [27:0]       len_arr [N_REQ];
    logic [ID_W-1:0]   rr, grant_id, scan_idx, issue_id;
    logic              grant_found, can_grant, pop, spurious;
    logic [ID_W-1:0]   id_fifo [MAX_OUT];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;

    for (genvar i = 0; i < int'(N_REQ); i++) begin : g_unpack
        assign src_arr[i] = req_src_addr[i*64 +: 64];
        assign dst_arr[i] = req_dst_addr[i*64 +: 64];
        assign len_arr[i] = req_len[i*28 +: 28];
    end

    // Round-robin search starting at rr.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            scan_idx = ID_W'((32'(rr) + k) % N_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_id    = scan_idx;
            end
        end
    end

    assign pop      = dsc_done && (outstanding != '0);
    assign spurious = dsc_done && (outstanding == '0);

    // Next state plus the combinational handshake outputs.
    always_comb begin
        state_d            = state_q;
        can_grant          = 1'b0;
        req_ready          = '0;
        h2c_dsc_byp_load_0 = 1'b0;
        case (state_q)
            ARB: begin
                can_grant = !axi_areset && grant_found && (outstanding < CNT_W'(MAX_OUT));
                if (can_grant) begin
                    req_ready = N_REQ'(1) << grant_id;
                    if (len_arr[grant_id] != '0) state_d = ISSUE;
                end
            end
            ISSUE: begin
                h2c_dsc_byp_load_0 = h2c_dsc_byp_ready_0 && !axi_areset;
                if (h2c_dsc_byp_ready_0) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q                <= ARB;
            rr                     <= '0;
            issue_id               <= '0;
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            outstanding            <= '0;
            h2c_dsc_byp_src_addr_0 <= '0;
            h2c_dsc_byp_dst_addr_0 <= '0;
            h2c_dsc_byp_len_0      <= '0;
            h2c_dsc_byp_ctl_0      <= '0;
            done_vec               <= '0;
            err_zero_len           <= 1'b0;
            err_spurious           <= 1'b0;
        end else begin
            state_q      <= state_d;
            done_vec     <= '0;
            err_zero_len <= 1'b0;
            err_spurious <= spurious;
            if (can_grant) begin
                rr                     <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
                issue_id               <= grant_id;
                h2c_dsc_byp_src_addr_0 <= src_arr[grant_id];
                h2c_dsc_byp_dst_addr_0 <= dst_arr[grant_id];
                h2c_dsc_byp_len_0      <= len_arr[grant_id];
                h2c_dsc_byp_ctl_0      <= DSC_CTL;
                err_zero_len           <= (len_arr[grant_id] == '0);
            end
            if (h2c_dsc_byp_load_0) begin
                wr_ptr <= (wr_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                done_vec <= N_REQ'(1) << id_fifo[rd_ptr];
                rd_ptr   <= (rd_ptr == PTR_W'(MAX_OUT - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({h2c_dsc_byp_load_0, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // ID storage needs no reset; pointers and count define validity.
    always_ff @(posedge axi_aclk) begin
        if (h2c_dsc_byp_load_0) id_fifo[wr_ptr] <= issue_id;
    end

endmodule
